// File: rtl/if_id_queue_pkg.sv
// Shared pipeline constants for the IF/ID instruction queue: the NOP word,
// the queue state encodings and the stored entry layout.
package if_id_queue_pkg;

  // addi x0, x0, 0 -- presented to decode whenever the queue is empty
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // Queue occupancy states; the encoding doubles as the entry count
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // One fetched instruction together with its PC
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_entry_t;

  // Sequential PC of an instruction; the 32-bit add wraps naturally
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_queue.sv
// Two-entry IF/ID decoupling queue between fetch and decode. Fetch pushes
// PC/instruction pairs, decode pops the head; EX redirects flush everything.
module if_id_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = if_id_queue_pkg::NOP_INST
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_PC,
  input  logic [31:0] IN_INST,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_PC,
  output logic [31:0] OUT_PC_PLUS4,
  output logic [31:0] OUT_INST,
  output logic [1:0]  COUNT
);

  import if_id_queue_pkg::*;

  logic [1:0]   state_q, state_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  if_id_entry_t entry_q [DEPTH];
  if_id_entry_t head;
  logic         push;
  logic         pop;

  // Handshakes: readiness only looks at occupancy, never at OUT_READY,
  // so a full queue refuses a push even when decode pops that cycle.
  assign IN_READY  = (state_q != ST_FULL);
  assign OUT_VALID = (state_q != ST_EMPTY);
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;
  assign COUNT     = state_q;

  // Head entry presented to decode, masked to a NOP bubble when empty
  always_comb begin
    head         = entry_q[rd_ptr_q];
    OUT_PC       = 32'd0;
    OUT_PC_PLUS4 = 32'd0;
    OUT_INST     = NOP_INST;
    if (OUT_VALID) begin
      OUT_PC       = head.pc;
      OUT_PC_PLUS4 = pc_plus4(head.pc);
      OUT_INST     = head.inst;
    end
  end

  // Next occupancy and pointers; a flush wins over any push or pop
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (FLUSH) begin
      state_d  = ST_EMPTY;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_FULL;
          else if (pop && !push) state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy and pointer registers, cleared immediately by reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry storage is written only on an accepted push; stale data is
  // harmless because the output mask hides it while the queue is empty.
  always_ff @(posedge CLK) begin
    if (push && !FLUSH) begin
      entry_q[wr_ptr_q] <= '{pc: IN_PC, inst: IN_INST};
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for the IF/ID instruction queue.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = 32'd0;
  logic [31:0] in_inst = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_inst;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  if_id_queue dut (
    .CLK          (clk),
    .RESET        (rst),
    .FLUSH        (flush),
    .IN_VALID     (in_valid),
    .IN_READY     (in_ready),
    .IN_PC        (in_pc),
    .IN_INST      (in_inst),
    .OUT_VALID    (out_valid),
    .OUT_READY    (out_ready),
    .OUT_PC       (out_pc),
    .OUT_PC_PLUS4 (out_pc_plus4),
    .OUT_INST     (out_inst),
    .COUNT        (count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and return on the following falling edge,
  // where outputs are sampled and new inputs are driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_inst !== NOP) begin errors++; $display("FAIL reset_out_inst got %h want %h", out_inst, NOP); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    checks++; if (out_pc_plus4 !== 32'd0) begin errors++; $display("FAIL reset_pc_plus4 got %h want 0", out_pc_plus4); end
    $display("test_reset: reset values observed");
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'h00500093; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_inst !== 32'h00500093) begin errors++; $display("FAIL single_inst got %h want 00500093", out_inst); end
    checks++; if (out_pc_plus4 !== 32'h4) begin errors++; $display("FAIL single_pc_plus4 got %h want 4", out_pc_plus4); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b want 0", out_valid); end
    checks++; if (out_inst !== NOP) begin errors++; $display("FAIL single_drain_inst got %h want %h", out_inst, NOP); end
    $display("test_single: push pc=0 inst=00500093, popped next cycle");
  endtask

  task automatic test_fill();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h10; in_inst = 32'h11111111; step();
    in_pc = 32'h14; in_inst = 32'h22222222; step();
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL fill_count got %0d want 2", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
    in_pc = 32'h18; in_inst = 32'h33333333; out_ready = 1'b1; step();
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL fill_no_push_when_full count got %0d want 1", count); end
    checks++; if (out_pc !== 32'h14) begin errors++; $display("FAIL fill_second_pc got %h want 14", out_pc); end
    checks++; if (out_inst !== 32'h22222222) begin errors++; $display("FAIL fill_second_inst got %h want 22222222", out_inst); end
    in_valid = 1'b0; step();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL fill_drain_count got %0d want 0 (0x18 must be ignored)", count); end
    $display("test_fill: pushed 10,14; 18 refused while full; popped 10 then 14");
  endtask

  task automatic test_fill_order();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h70; in_inst = 32'hAAAA0001; step();
    in_pc = 32'h74; in_inst = 32'hAAAA0002; step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h70) begin errors++; $display("FAIL order_head_pc got %h want 70", out_pc); end
    out_ready = 1'b1; step();
    checks++; if (out_pc !== 32'h74) begin errors++; $display("FAIL order_next_pc got %h want 74", out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL order_in_ready got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %b want 0", out_valid); end
    $display("test_fill_order: popped 70 then 74 in push order");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h20; in_inst = 32'hB0000020; step();
    checks++; if (out_pc !== 32'h20) begin errors++; $display("FAIL b2b_head got %h want 20", out_pc); end
    in_pc = 32'h24; in_inst = 32'hB0000024; out_ready = 1'b1; step();
    in_valid = 1'b0;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_count got %0d want 1", count); end
    checks++; if (out_pc !== 32'h24) begin errors++; $display("FAIL b2b_pc got %h want 24", out_pc); end
    checks++; if (out_pc_plus4 !== 32'h28) begin errors++; $display("FAIL b2b_pc_plus4 got %h want 28", out_pc_plus4); end
    checks++; if (out_inst !== 32'hB0000024) begin errors++; $display("FAIL b2b_inst got %h want b0000024", out_inst); end
    step();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL b2b_drain got %0d want 0", count); end
    $display("test_back_to_back: push 24 with pop of 20 kept count at 1");
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h30; in_inst = 32'hC0000030; step();
    in_pc = 32'h34; in_inst = 32'hC0000034; step();
    flush = 1'b1; in_pc = 32'h40; in_inst = 32'hC0000040; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_full_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_0x40_appeared pc %h valid %b want invalid", out_pc, out_valid); end
    // Flush in ONE with a simultaneous (accepted-looking) push: push discarded
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h50; in_inst = 32'hC0000050; step();
    flush = 1'b1; in_pc = 32'h54; in_inst = 32'hC0000054; step();
    flush = 1'b0;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_push_count got %0d want 0", count); end
    in_pc = 32'h58; in_inst = 32'hC0000058; step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h58) begin errors++; $display("FAIL flush_restart_pc got %h want 58", out_pc); end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL flush_restart_count got %0d want 1", count); end
    out_ready = 1'b1; step();
    $display("test_flush: flush discarded queue and concurrent push");
  endtask

  task automatic test_wrap();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'hFFFFFFFC; in_inst = 32'hD00000FC; step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pc got %h want fffffffc", out_pc); end
    checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got %h want 0", out_pc_plus4); end
    out_ready = 1'b1; step();
    $display("test_wrap: pc fffffffc -> plus4 00000000");
  endtask

  task automatic test_idle_pop();
    out_ready = 1'b1; in_valid = 1'b0; step();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL idle_pop_count got %0d want 0", count); end
    in_valid = 1'b1; in_pc = 32'h80; in_inst = 32'hE0000080; out_ready = 1'b0; step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h80) begin errors++; $display("FAIL idle_pop_then_push got %h want 80", out_pc); end
    out_ready = 1'b1; step();
    $display("test_idle_pop: pop on empty queue ignored");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h60; in_inst = 32'hF0000060; step();
    in_pc = 32'h64; in_inst = 32'hF0000064; step();
    in_valid = 1'b0;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL areset_pre_full got %0d want 2", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL areset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %b want 1", in_ready); end
    checks++; if (out_inst !== NOP) begin errors++; $display("FAIL areset_inst got %h want %h", out_inst, NOP); end
    checks++; if (out_pc_plus4 !== 32'd0) begin errors++; $display("FAIL areset_pc_plus4 got %h want 0", out_pc_plus4); end
    #1 rst = 1'b0;
    in_valid = 1'b1; in_pc = 32'h68; in_inst = 32'hF0000068; step();
    in_valid = 1'b0;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL areset_push_count got %0d want 1", count); end
    checks++; if (out_pc !== 32'h68) begin errors++; $display("FAIL areset_push_pc got %h want 68", out_pc); end
    $display("test_async_reset: reset between edges cleared full queue");
  endtask

  initial begin
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_single();
    test_fill();
    test_fill_order();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_idle_pop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of instruction entries (fixed at 2; other values unsupported).
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, meaning the instruction presented to decode when no entry is valid (addi x0,x0,0).
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  reset is asynchronous and active-high.
REQ-005 FLUSH  input  1  discards all entries (branch/jump redirect from EX).
REQ-006 IN_VALID  input  1  fetch presents a valid PC/instruction pair.
REQ-007 IN_READY  output  1  queue accepts a push this cycle.
REQ-008 IN_PC  input  32  PC of the fetched instruction.
REQ-009 IN_INST  input  32  fetched instruction word.
REQ-010 OUT_VALID  output  1  head entry is valid for decode.
REQ-011 OUT_READY  input  1  decode consumes the head this cycle (deasserted by the hazard unit on a load-use stall).
REQ-012 OUT_PC  output  32  PC of the head entry.
REQ-013 OUT_PC_PLUS4  output  32  OUT_PC + 4.
REQ-014 OUT_INST  output  32  head instruction; drives the decoder and immediate generator.
REQ-015 COUNT  output  2  number of valid entries (0..2).

Function
REQ-016 SHALL implement a 2-entry FIFO with states EMPTY (COUNT=0), ONE (COUNT=1), FULL (COUNT=2).
REQ-017 Push SHALL occur when IN_VALID && IN_READY; pop when OUT_VALID && OUT_READY.
REQ-018 IN_READY SHALL equal (COUNT != 2) and SHALL NOT depend combinationally on OUT_READY; no push while FULL, even with a simultaneous pop.
REQ-019 Transitions: EMPTY+push -> ONE; ONE+push only -> FULL; ONE+pop only -> EMPTY; ONE+push+pop -> ONE; FULL+pop -> ONE; all other cases hold.
REQ-020 Latency: a pushed entry SHALL appear on OUT_* in the cycle after the push edge when the queue was EMPTY; entries SHALL pop in push order.
REQ-021 Simultaneous push and pop in ONE SHALL present the newly pushed entry at the head next cycle.
REQ-022 Read and write pointers SHALL be 1 bit wide and wrap modulo 2.
REQ-023 OUT_VALID SHALL equal (COUNT != 0).
REQ-024 When OUT_VALID=0, OUT_INST SHALL equal NOP_INST and OUT_PC and OUT_PC_PLUS4 SHALL be 0.
REQ-025 OUT_PC_PLUS4 SHALL be a 32-bit sum that wraps (32'hFFFFFFFC -> 32'h00000000).
REQ-026 FLUSH SHALL take priority over push and pop in the same cycle: next state EMPTY, both pointers 0, and the simultaneous push discarded.
REQ-027 OUT_READY while OUT_VALID=0 SHALL have no effect.
REQ-028 Entry storage SHALL only be written on push; stale entries need not be cleared.

Reset
REQ-029 Asserting RESET SHALL immediately force COUNT=0, both pointers 0, OUT_VALID=0, IN_READY=1, OUT_INST=NOP_INST, OUT_PC=0, OUT_PC_PLUS4=32'h4 masked to 0 per REQ-024.
REQ-030 RESET asserted mid-operation SHALL discard all entries, and the first rising edge after deassertion SHALL accept a push.

Structure
REQ-031 NOP_INST and the state encodings (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) SHALL be defined in the shared pipeline constants package.
REQ-032 No sub-module SHALL be used; storage, pointers and state logic are flat in if_id_queue.

Verification
REQ-033 Reset, then push PC=0x0/INST=0x00500093 with OUT_READY=1 -> next cycle OUT_VALID=1, OUT_INST=0x00500093, OUT_PC_PLUS4=0x4; following cycle OUT_VALID=0, OUT_INST=0x00000013.
REQ-034 OUT_READY=0, push PCs 0x10 and 0x14 -> COUNT=2, IN_READY=0, and a third push of 0x18 is ignored; then OUT_READY=1 for two cycles -> output 0x10 then 0x14.
REQ-035 In ONE (head 0x20), push 0x24 and pop together -> COUNT stays 1 and OUT_PC=0x24 next cycle.
REQ-036 In FULL, assert FLUSH with IN_VALID=1 (PC 0x40) -> next cycle COUNT=0, OUT_VALID=0, and 0x40 is never output.
REQ-037 Push PC=0xFFFFFFFC -> OUT_PC_PLUS4=0x00000000.
REQ-038 Assert RESET asynchronously between edges while FULL -> outputs take reset values before the next edge; a push after deassertion -> COUNT=1.
